// File: rtl/digit_mux_if.sv
// Bundle of the switch inputs and display outputs shared by the digit
// multiplex controller (slave) and whatever drives or observes it (master).
interface digit_mux_if;
  logic       en;
  logic [3:0] s0;
  logic [3:0] s1;
  logic [3:0] hex;
  logic [1:0] an;
  logic       sel;
  logic       frame_tick;

  modport master (
    output en, s0, s1,
    input  hex, an, sel, frame_tick
  );

  modport slave (
    input  en, s0, s1,
    output hex, an, sel, frame_tick
  );
endinterface

// File: rtl/digit_mux_ctrl.sv
// Two-digit time-multiplex scheduler for a shared hex-to-seven-segment decoder,
// with optional blanking between digits and active-low anode enables.
module digit_mux_ctrl #(
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input logic        clk,
  input logic        reset,
  digit_mux_if.slave bus
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK0 = 3'd1,
    SHOW0  = 3'd2,
    BLANK1 = 3'd3,
    SHOW1  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hex_q;
  logic [1:0]       an_q;
  logic             sel_q;
  logic             tick_q;

  // Next state and counter; every state change reloads the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = HAS_BLANK ? BLANK0 : SHOW0;
          cnt_d   = '0;
        end
        BLANK0: if (cnt_q == BLANK_LAST) begin
          state_d = SHOW0;
          cnt_d   = '0;
        end
        SHOW0: if (cnt_q == DWELL_LAST) begin
          state_d = HAS_BLANK ? BLANK1 : SHOW1;
          cnt_d   = '0;
        end
        BLANK1: if (cnt_q == BLANK_LAST) begin
          state_d = SHOW1;
          cnt_d   = '0;
        end
        SHOW1: if (cnt_q == DWELL_LAST) begin
          state_d = HAS_BLANK ? BLANK0 : SHOW0;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the upcoming state so they line up with it;
  // a digit value is captured only on the edge that enters its SHOW state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      an_q    <= 2'b11;
      hex_q   <= 4'h0;
      sel_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unique case (state_d)
        SHOW0:   an_q <= 2'b10;
        SHOW1:   an_q <= 2'b01;
        default: an_q <= 2'b11;
      endcase
      tick_q <= (state_d == SHOW1) && (cnt_d == DWELL_LAST);
      if (state_d == SHOW0 && state_q != SHOW0) begin
        hex_q <= bus.s0;
        sel_q <= 1'b0;
      end else if (state_d == SHOW1 && state_q != SHOW1) begin
        hex_q <= bus.s1;
        sel_q <= 1'b1;
      end
    end
  end

  assign bus.hex        = hex_q;
  assign bus.an         = an_q;
  assign bus.sel        = sel_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_digit_mux_ctrl.sv
// Bench for digit_mux_ctrl: one instance with blanking (D=4,B=2) and one without
// (D=4,B=0), both driven by the same directed stimulus and checked every cycle.
module tb_digit_mux_ctrl;

  localparam int D  = 4;
  localparam int BA = 2;
  localparam int BB = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] s0, s1;

  int checks   = 0;
  int failures = 0;

  digit_mux_if ifa ();
  digit_mux_if ifb ();

  assign ifa.en = en;
  assign ifa.s0 = s0;
  assign ifa.s1 = s1;
  assign ifb.en = en;
  assign ifb.s0 = s0;
  assign ifb.s1 = s1;

  digit_mux_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(BA)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  digit_mux_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(BB)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time since the display started (-1 = idle); everything else is the
  // position of that time inside a frame of 2*(B+D) cycles.
  function automatic int next_rt(input int rt);
    if (reset || !en) return -1;
    return rt + 1;
  endfunction

  function automatic int phase(input int rt, input int b);
    return rt % (2 * (b + D));
  endfunction

  function automatic logic [1:0] exp_an(input int rt, input int b);
    int f;
    if (rt < 0) return 2'b11;
    f = phase(rt, b);
    if (f < b)         return 2'b11;
    if (f < b + D)     return 2'b10;
    if (f < 2 * b + D) return 2'b11;
    return 2'b01;
  endfunction

  function automatic logic exp_tick(input int rt, input int b);
    if (rt < 0) return 1'b0;
    return phase(rt, b) == 2 * (b + D) - 1;
  endfunction

  int         rt_a = -1, rt_b = -1;
  logic [3:0] mhex_a = 4'h0, mhex_b = 4'h0;
  logic       msel_a = 1'b0, msel_b = 1'b0;

  always @(posedge clk) begin
    rt_a <= next_rt(rt_a);
    rt_b <= next_rt(rt_b);
    if (reset) begin
      mhex_a <= 4'h0; msel_a <= 1'b0;
      mhex_b <= 4'h0; msel_b <= 1'b0;
    end else if (en) begin
      if (phase(rt_a + 1, BA) == BA) begin
        mhex_a <= s0; msel_a <= 1'b0;
      end else if (phase(rt_a + 1, BA) == 2 * BA + D) begin
        mhex_a <= s1; msel_a <= 1'b1;
      end
      if (phase(rt_b + 1, BB) == BB) begin
        mhex_b <= s0; msel_b <= 1'b0;
      end else if (phase(rt_b + 1, BB) == 2 * BB + D) begin
        mhex_b <= s1; msel_b <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("a_an",   {6'd0, ifa.an},         {6'd0, exp_an(rt_a, BA)});
    chk("a_hex",  {4'd0, ifa.hex},        {4'd0, mhex_a});
    chk("a_sel",  {7'd0, ifa.sel},        {7'd0, msel_a});
    chk("a_tick", {7'd0, ifa.frame_tick}, {7'd0, exp_tick(rt_a, BA)});
    chk("b_an",   {6'd0, ifb.an},         {6'd0, exp_an(rt_b, BB)});
    chk("b_hex",  {4'd0, ifb.hex},        {4'd0, mhex_b});
    chk("b_sel",  {7'd0, ifb.sel},        {7'd0, msel_b});
    chk("b_tick", {7'd0, ifb.frame_tick}, {7'd0, exp_tick(rt_b, BB)});
    chk("a_not_both_lit", {7'd0, ifa.an == 2'b00}, 8'd0);
    chk("b_not_both_lit", {7'd0, ifb.an == 2'b00}, 8'd0);
  end

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    s0    = 4'h3;
    s1    = 4'hA;
    repeat (3) begin
      @(negedge clk);
      chk("lit_rst_an",   {6'd0, ifa.an}, 8'h03);
      chk("lit_rst_hex",  {4'd0, ifa.hex}, 8'h00);
      chk("lit_rst_sel",  {7'd0, ifa.sel}, 8'h00);
      chk("lit_rst_tick", {7'd0, ifa.frame_tick}, 8'h00);
    end
    reset = 1'b0;

    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      case (n)
        1: begin
          chk("lit_a_blank_first", {6'd0, ifa.an}, 8'h03);
          chk("lit_b_show0_an",    {6'd0, ifb.an}, 8'h02);
          chk("lit_b_show0_hex",   {4'd0, ifb.hex}, 8'h03);
        end
        2:  chk("lit_a_blank_second", {6'd0, ifa.an}, 8'h03);
        3: begin
          chk("lit_a_show0_an",  {6'd0, ifa.an}, 8'h02);
          chk("lit_a_show0_hex", {4'd0, ifa.hex}, 8'h03);
          chk("lit_a_show0_sel", {7'd0, ifa.sel}, 8'h00);
        end
        5: begin
          chk("lit_b_show1_an",  {6'd0, ifb.an}, 8'h01);
          chk("lit_b_show1_hex", {4'd0, ifb.hex}, 8'h0A);
          chk("lit_b_show1_sel", {7'd0, ifb.sel}, 8'h01);
        end
        8:  chk("lit_b_tick", {7'd0, ifb.frame_tick}, 8'h01);
        9: begin
          chk("lit_a_show1_an",  {6'd0, ifa.an}, 8'h01);
          chk("lit_a_show1_hex", {4'd0, ifa.hex}, 8'h0A);
          chk("lit_a_show1_sel", {7'd0, ifa.sel}, 8'h01);
        end
        11: chk("lit_a_no_early_tick", {7'd0, ifa.frame_tick}, 8'h00);
        12: chk("lit_a_tick", {7'd0, ifa.frame_tick}, 8'h01);
        16: begin
          chk("lit_a_show0_2nd", {6'd0, ifa.an}, 8'h02);
          s0 = 4'h5;
        end
        17: chk("lit_a_hex_latched", {4'd0, ifa.hex}, 8'h03);
        22: begin
          chk("lit_a_show1_2nd", {6'd0, ifa.an}, 8'h01);
          en = 1'b0;
        end
        23: begin
          chk("lit_dis_an",   {6'd0, ifa.an}, 8'h03);
          chk("lit_dis_tick", {7'd0, ifa.frame_tick}, 8'h00);
          chk("lit_dis_hex",  {4'd0, ifa.hex}, 8'h0A);
        end
        24: begin
          chk("lit_dis_a_an", {6'd0, ifa.an}, 8'h03);
          chk("lit_dis_b_an", {6'd0, ifb.an}, 8'h03);
        end
        25: en = 1'b1;
        26: chk("lit_reen_blank1", {6'd0, ifa.an}, 8'h03);
        27: chk("lit_reen_blank2", {6'd0, ifa.an}, 8'h03);
        28: begin
          chk("lit_reen_show0_an",  {6'd0, ifa.an}, 8'h02);
          chk("lit_reen_show0_hex", {4'd0, ifa.hex}, 8'h05);
        end
        29: reset = 1'b1;
        30: begin
          chk("lit_mid_rst_an",   {6'd0, ifa.an}, 8'h03);
          chk("lit_mid_rst_hex",  {4'd0, ifa.hex}, 8'h00);
          chk("lit_mid_rst_sel",  {7'd0, ifa.sel}, 8'h00);
          chk("lit_mid_rst_tick", {7'd0, ifa.frame_tick}, 8'h00);
          chk("lit_mid_rst_b_an", {6'd0, ifb.an}, 8'h03);
          reset = 1'b0;
        end
        31: chk("lit_restart_blank1", {6'd0, ifa.an}, 8'h03);
        32: chk("lit_restart_blank2", {6'd0, ifa.an}, 8'h03);
        33: begin
          chk("lit_restart_show0_an",  {6'd0, ifa.an}, 8'h02);
          chk("lit_restart_show0_hex", {4'd0, ifa.hex}, 8'h05);
        end
        40: s1 = 4'hC;
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
